// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus definitions.
// Sprite-DMA state encoding, bus parity and fixed addresses.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_t;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  localparam int          DMA_BYTES = 256;
  localparam logic [7:0]  LAST_IDX  = 8'(DMA_BYTES - 1);

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side pins and arbitrated system-bus pins of the sprite DMA.
// master = the arbiter, slave = CPU core plus memory map.
interface oam_dma_ctrl_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_rnw;
  logic [7:0]  bus_data_in;

  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_rnw;
  logic        cpu_rdy;
  logic        dma_active;
  logic [7:0]  dma_idx;

  modport master (
    input  cpu_addr,
    input  cpu_data_out,
    input  cpu_rnw,
    input  bus_data_in,
    output bus_addr,
    output bus_data_out,
    output bus_rnw,
    output cpu_rdy,
    output dma_active,
    output dma_idx
  );

  modport slave (
    output cpu_addr,
    output cpu_data_out,
    output cpu_rnw,
    output bus_data_in,
    input  bus_addr,
    input  bus_data_out,
    input  bus_rnw,
    input  cpu_rdy,
    input  dma_active,
    input  dma_idx
  );

endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA controller and bus arbiter: snoops $4014 writes,
// stalls the CPU and copies one 256-byte page into OAM.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic          clk_ph1,
  input  logic          rst,
  oam_dma_ctrl_if.master bus
);

  dma_state_t r_state;
  parity_t    r_odd;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic [7:0] r_dl;

  logic       w_trig;

  assign w_trig = (bus.cpu_addr == DMA_REG_ADDR) && !bus.cpu_rnw;

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_odd   <= PAR_EVEN;
      r_page  <= 8'd0;
      r_idx   <= 8'd0;
      r_dl    <= 8'd0;
    end else begin
      r_odd <= (r_odd == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
      unique case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            r_page  <= bus.cpu_data_out;
            r_idx   <= 8'd0;
            r_state <= ST_HALT;
          end
        end
        // an odd halt cycle needs one extra cycle to realign
        ST_HALT: begin
          r_state <= (r_odd == PAR_ODD) ? ST_ALIGN : ST_READ;
        end
        ST_ALIGN: begin
          r_state <= ST_READ;
        end
        ST_READ: begin
          r_dl    <= bus.bus_data_in;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_idx   <= r_idx + 8'd1;
          r_state <= (r_idx == LAST_IDX) ? ST_IDLE : ST_READ;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.bus_addr     = bus.cpu_addr;
    bus.bus_data_out = bus.cpu_data_out;
    bus.bus_rnw      = bus.cpu_rnw;
    unique case (1'b1)
      (r_state == ST_HALT),
      (r_state == ST_ALIGN): begin
        bus.bus_rnw = 1'b1;
      end
      (r_state == ST_READ): begin
        bus.bus_addr = {r_page, r_idx};
        bus.bus_rnw  = 1'b1;
      end
      (r_state == ST_WRITE): begin
        bus.bus_addr     = OAM_DATA_ADDR;
        bus.bus_data_out = r_dl;
        bus.bus_rnw      = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign bus.cpu_rdy    = (r_state == ST_IDLE);
  assign bus.dma_active = (r_state != ST_IDLE);
  assign bus.dma_idx    = r_idx;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl.
// OAM write data is queued at trigger time and popped per write.
module tb_oam_dma_ctrl;

  logic clk_ph1 = 1'b0;
  logic rst     = 1'b0;
  bit   m_odd;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  oam_dma_ctrl_if bus();

  oam_dma_ctrl dut (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_ph1 = ~clk_ph1;

  // reference parity: cleared by reset, toggles every edge
  always @(posedge clk_ph1) m_odd <= !rst ? 1'b0 : ~m_odd;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h58;
  endfunction

  assign bus.bus_data_in = mem_rd(bus.bus_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic drive(input logic [15:0] a,
                       input logic [7:0] d,
                       input logic r);
    bus.cpu_addr     = a;
    bus.cpu_data_out = d;
    bus.cpu_rnw      = r;
  endtask

  task automatic chk_pass(input string tag);
    chk({tag, "_addr"}, bus.bus_addr, bus.cpu_addr);
    chk({tag, "_data"}, bus.bus_data_out, bus.cpu_data_out);
    chk({tag, "_rnw"}, bus.bus_rnw, bus.cpu_rnw);
  endtask

  // trigger in a cycle chosen so HALT lands with the wanted parity
  task automatic trigger(input logic [7:0] pg, input bit halt_odd);
    int g;
    g = 0;
    cyc();
    while (m_odd == halt_odd && g < 8) begin
      cyc();
      g++;
    end
    drive(16'h4014, pg, 1'b0);
    for (int i = 0; i < 256; i++)
      exp_q.push_back(mem_rd({pg, 8'(i)}));
    @(negedge clk_ph1);
    cyc();
    drive(16'h1234, 8'hEE, 1'b1);
    @(negedge clk_ph1);
    chk("latency_rdy", bus.cpu_rdy, 1'b0);
  endtask

  task automatic dma_run(input logic [7:0] pg, input bit halt_odd);
    int stalled, dummy, nrd, nwr, zhit, g;
    logic [15:0] first_a, last_a;
    stalled = 0; dummy = 0; nrd = 0; nwr = 0; zhit = 0; g = 0;
    first_a = '0; last_a = '0;
    trigger(pg, halt_odd);
    while (!bus.cpu_rdy && g < 700) begin
      stalled++;
      if (bus.bus_rnw && bus.bus_addr == 16'h1234) dummy++;
      if (bus.bus_rnw && bus.bus_addr[15:8] == pg) begin
        if (nrd == 0) first_a = bus.bus_addr;
        last_a = bus.bus_addr;
        nrd++;
      end
      if (!bus.bus_rnw && bus.bus_addr == 16'h2004) begin
        nwr++;
        if (exp_q.size() > 0)
          chk("wdata", bus.bus_data_out, exp_q.pop_front());
        else
          chk("wextra", nwr, 0);
      end
      if (bus.bus_addr == 16'h0000) zhit++;
      cyc();
      @(negedge clk_ph1);
      g++;
    end
    chk("timeout", (g < 700), 1'b1);
    chk("stalled", stalled, halt_odd ? 514 : 513);
    chk("dummy", dummy, halt_odd ? 2 : 1);
    chk("nreads", nrd, 256);
    chk("nwrites", nwr, 256);
    chk("first_rd", first_a, {pg, 8'h00});
    chk("last_rd", last_a, {pg, 8'hFF});
    chk("zero_hit", zhit, 0);
    chk("q_empty", exp_q.size(), 0);
    chk("post_active", bus.dma_active, 1'b0);
    chk_pass("post");
  endtask

  task automatic mid_reset();
    int g, nwr;
    g = 0; nwr = 0;
    trigger(8'h02, 1'b0);
    while (!(bus.dma_idx == 8'd100 && !bus.bus_rnw) && g < 700) begin
      if (!bus.bus_rnw && bus.bus_addr == 16'h2004)
        chk("mr_wdata", bus.bus_data_out, exp_q.pop_front());
      cyc();
      @(negedge clk_ph1);
      g++;
    end
    chk("mr_reach", (g < 700), 1'b1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk_ph1);
    chk("mr_rdy", bus.cpu_rdy, 1'b1);
    chk("mr_active", bus.dma_active, 1'b0);
    chk("mr_idx", bus.dma_idx, 8'd0);
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      if (!bus.bus_rnw && bus.bus_addr == 16'h2004) nwr++;
      cyc();
      @(negedge clk_ph1);
    end
    chk("mr_nowrite", nwr, 0);
  endtask

  initial begin
    drive($urandom, $urandom, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(16'($urandom), 8'($urandom), 1'($urandom));
      @(negedge clk_ph1);
      chk_pass("rst_pass");
    end
    chk("rst_rdy", bus.cpu_rdy, 1'b1);
    chk("rst_active", bus.dma_active, 1'b0);
    chk("rst_idx", bus.dma_idx, 8'd0);
    cyc();
    rst = 1'b1;
    drive(16'h1234, 8'h00, 1'b1);

    dma_run(8'h02, 1'b0);
    dma_run(8'h02, 1'b1);
    dma_run(8'hFF, 1'b0);

    mid_reset();

    // trigger and reset on the same edge
    cyc();
    rst = 1'b0;
    drive(16'h4014, 8'h02, 1'b0);
    cyc();
    rst = 1'b1;
    drive(16'h1234, 8'h00, 1'b1);
    @(negedge clk_ph1);
    chk("rst_wins", bus.cpu_rdy, 1'b1);

    cyc();
    drive(16'h4014, 8'h02, 1'b1);
    @(negedge clk_ph1);
    chk_pass("nt_rd");
    chk("nt_rd_active", bus.dma_active, 1'b0);
    cyc();
    drive(16'h4015, 8'h07, 1'b0);
    @(negedge clk_ph1);
    chk_pass("nt_wr");
    chk("nt_wr_active", bus.dma_active, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(16'h0100 + 16'(i), 8'(i), 1'b1);
      @(negedge clk_ph1);
      chk_pass("nt_after");
      chk("nt_after_active", bus.dma_active, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite-DMA controller and bus arbiter for the NES system bus. It snoops CPU writes to the DMA page register ($4014), halts the CPU, and takes over the shared address/data bus. It then copies 256 bytes from CPU page $PP00–$PPFF to the PPU OAM data port ($2004) and returns the bus to the CPU. It sits between the CPU core's external bus pins and the system address decoder/memory map.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write

Ports:
- clk_ph1  in  1  system clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- cpu_addr  in  16  CPU address bus
- cpu_data_out  in  8  CPU output data bus
- cpu_rnw  in  1  CPU read/not-write
- bus_data_in  in  8  read data returned by the memory map
- bus_addr  out  16  arbitrated system address
- bus_data_out  out  8  arbitrated system write data
- bus_rnw  out  1  arbitrated read/not-write
- cpu_rdy  out  1  1 = CPU may advance; 0 = CPU stalled
- dma_active  out  1  1 while the controller owns the bus (HALT through last WRITE)
- dma_idx  out  8  current byte index (debug)

## Operation
- Free-running parity bit `odd` toggles every clk_ph1 edge. It resets to 0.
- States: IDLE, HALT, ALIGN, READ, WRITE. The state and `odd` are encoded in the shared package.
- IDLE: the bus passes through. bus_addr = cpu_addr, bus_data_out = cpu_data_out, bus_rnw = cpu_rnw.
  - If the edge sees cpu_addr == DMA_REG_ADDR and cpu_rnw == 0, then page <= cpu_data_out[7:0], idx <= 0, and the next state is HALT.
- HALT: one cycle. bus_addr = cpu_addr, bus_rnw forced to 1 (dummy read), bus_data_out = cpu_data_out.
  - Next state is ALIGN if `odd` == 1 during HALT, otherwise READ.
- ALIGN: one cycle with the same bus drive as HALT. Next state is READ.
- READ: bus_addr = {page, idx}, bus_rnw = 1. The edge ending READ captures bus_data_in into the data latch `dl`. Next state is WRITE.
- WRITE: bus_addr = OAM_DATA_ADDR, bus_rnw = 0, bus_data_out = dl. The edge ending WRITE increments idx (8-bit).
  - If idx was 8'hFF, the next state is IDLE; otherwise READ.
- cpu_rdy = (state == IDLE). dma_active = (state != IDLE). Both are decoded from registered state.
- Outside READ/WRITE, the bus mux is a pure function of the state register and CPU inputs.

## Timing
- Reset values: state IDLE, page 0, idx 0, dl 0, odd 0. Hence cpu_rdy = 1, dma_active = 0, dma_idx = 0, and the bus in pass-through.
- Trigger latency: the $4014 write occurs in cycle T; HALT occupies cycle T+1 and cpu_rdy = 0 from T+1.
- Transfer length:
  - 513 halted cycles when HALT falls on an even cycle (1 + 512).
  - 514 halted cycles when HALT falls on an odd cycle (1 + 1 + 512).
  - cpu_rdy returns to 1 in the cycle after the 256th WRITE.
- Each byte takes exactly 2 cycles, READ then WRITE. There are no gaps between pairs.
- Page $FF: addresses wrap inside the page ($FF00–$FFFF). The page never increments.
- Writes to $4014 while not IDLE are ignored; the CPU is stalled, so none are expected.
- A reads of $4014 never triggers a transfer.
- rst low in any state: the next state is IDLE with all registers at reset values, regardless of the DMA position. No partial completion.
- The trigger write and rst low on the same edge: reset wins.

## Structure
- Shared package nes_bus_pkg holds:
  - the state enum (IDLE/HALT/ALIGN/READ/WRITE);
  - address constants $4014 and $2004, used as parameter defaults;
  - the DMA byte count 256.
- Single module. The bus mux, parity flop and FSM are small enough that no sub-module is warranted.

## Test plan
- Reset: hold rst = 0 for 3 cycles with a random CPU bus, then check:
  - cpu_rdy = 1, dma_active = 0;
  - bus_addr/bus_data_out/bus_rnw equal the CPU inputs in the same cycle.
- Even-aligned DMA:
  - Stimulus: write $02 to $4014 so HALT lands with odd = 0; the memory model holds $0200+i = i^8'h5A.
  - Required: 513 cycles with cpu_rdy = 0; 256 writes to $2004 carrying i^8'h5A in order, i = 0..255; the first READ address is $0200 and the last is $02FF.
- Odd-aligned DMA: same as the even case with HALT on odd = 1.
  - Required: exactly one ALIGN cycle, 514 stalled cycles, identical data sequence.
- Page $FF wrap:
  - Stimulus: write $FF to $4014.
  - Required: the last READ address is $FFFF, then IDLE; no access to $0000.
- Reset mid-transfer: assert rst at idx = 100 during WRITE.
  - Required: the next cycle is IDLE with cpu_rdy = 1 and idx = 0; no further $2004 writes.
- Non-trigger accesses: a read of $4014, and a write to $4015 with data $07.
  - Required: dma_active stays 0; pass-through is maintained on every cycle.
